// File: rtl/nw_pkg.sv
// Shared types and scoring constants for the Needleman-Wunsch fill sequencer.
package nw_pkg;

    localparam int SCORE_W      = 9;
    localparam int DEF_MATCH    = 1;
    localparam int DEF_MISMATCH = -1;
    localparam int DEF_GAP      = -2;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic signed [SCORE_W:0]   wide_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_CALC,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    // Clamp a one-bit-wider sum back into the score range.
    function automatic score_t saturate(input wide_t v);
        if (v[SCORE_W] != v[SCORE_W-1])
            return {v[SCORE_W], {(SCORE_W-1){~v[SCORE_W]}}};
        return v[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/nw_fill_ctrl_max3.sv
// Cell score: best of diag+match/mismatch, up+gap, left+gap, saturated.
module nw_max3
    import nw_pkg::*;
#(
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int GAP      = DEF_GAP
) (
    input  logic signed [SCORE_W-1:0] diag,
    input  logic signed [SCORE_W-1:0] up,
    input  logic signed [SCORE_W-1:0] left,
    input  logic                      match,
    output logic signed [SCORE_W-1:0] max
);

    wide_t d_w;
    wide_t u_w;
    wide_t l_w;
    wide_t best;

    always_comb begin
        d_w  = wide_t'(diag) + (match ? wide_t'(MATCH) : wide_t'(MISMATCH));
        u_w  = wide_t'(up) + wide_t'(GAP);
        l_w  = wide_t'(left) + wide_t'(GAP);
        best = d_w;
        if (u_w > best) best = u_w;
        if (l_w > best) best = l_w;
    end

    assign max = saturate(best);

endmodule

// File: rtl/nw_fill_ctrl.sv
// Border init, neighbour read, and cell insert sequencing for the
// score-matrix fill, walking cells row-major.
module nw_fill_ctrl
    import nw_pkg::*;
#(
    parameter int N        = 5,
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int GAP      = DEF_GAP,
    localparam int BitAddr = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      match,
    input  logic                      signal,
    input  logic signed [SCORE_W-1:0] diag,
    input  logic signed [SCORE_W-1:0] up,
    input  logic signed [SCORE_W-1:0] left,
    output logic                      en_init,
    output logic                      we,
    output logic [BitAddr:0]          addr_init,
    output logic signed [SCORE_W-1:0] data_init,
    output logic                      en_read,
    output logic                      en_ins,
    output logic [BitAddr:0]          i,
    output logic [BitAddr:0]          j,
    output logic signed [SCORE_W-1:0] max,
    output logic                      change_index,
    output logic                      busy,
    output logic                      done
);

    typedef logic [BitAddr:0] idx_t;

    localparam idx_t LAST_K  = idx_t'(N);
    localparam idx_t LAST_IJ = idx_t'(N - 1);
    localparam idx_t ONE     = idx_t'(1);

    state_t state_q, state_d;
    idx_t   k_q, k_d;
    idx_t   i_q, i_d;
    idx_t   j_q, j_d;
    score_t max_q, max_d;
    score_t cell_max;
    logic   sig_q;

    nw_max3 #(
        .MATCH   (MATCH),
        .MISMATCH(MISMATCH),
        .GAP     (GAP)
    ) u_max3 (
        .diag (diag),
        .up   (up),
        .left (left),
        .match(match),
        .max  (cell_max)
    );

    // sig_q follows signal every cycle, so only a toggle seen while in READ counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            max_q   <= '0;
            sig_q   <= signal;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            max_q   <= max_d;
            sig_q   <= signal;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        i_d          = i_q;
        j_d          = j_q;
        max_d        = max_q;
        en_init      = 1'b0;
        we           = 1'b0;
        addr_init    = '0;
        data_init    = '0;
        en_read      = 1'b0;
        en_ins       = 1'b0;
        change_index = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    k_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            S_INIT: begin
                en_init   = 1'b1;
                we        = 1'b1;
                busy      = 1'b1;
                addr_init = k_q;
                data_init = score_t'(int'(k_q) * GAP);
                if (k_q == LAST_K) state_d = S_READ;
                else               k_d     = k_q + ONE;
            end
            S_READ: begin
                en_read = 1'b1;
                busy    = 1'b1;
                if (signal != sig_q) state_d = S_CALC;
            end
            S_CALC: begin
                busy    = 1'b1;
                max_d   = cell_max;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                en_ins  = 1'b1;
                we      = 1'b1;
                busy    = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                change_index = 1'b1;
                busy         = 1'b1;
                if (j_q < LAST_IJ) begin
                    j_d = j_q + ONE;
                end else begin
                    j_d = '0;
                    i_d = i_q + ONE;
                end
                if (i_q == LAST_IJ && j_q == LAST_IJ) state_d = S_DONE;
                else                                  state_d = S_READ;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign i   = i_q;
    assign j   = j_q;
    assign max = max_q;

endmodule

// File: doc/nw_fill_ctrl.md
# nw_fill_ctrl

Sequencer for the Needleman-Wunsch score-matrix fill. It drives the score RAM manager through three phases: border initialisation, then a per-cell read of the diag/up/left neighbours, then insertion of the computed cell maximum, walking cells row-major from (1,1) to (N,N). It sits between the top-level start/done control and the score manager, and takes one match/mismatch bit per cell from the sequence-compare logic.

## Interface
- N, 5, sequence length; the matrix is (N+1)x(N+1)
- MATCH, 1, signed score added to diag on a symbol match
- MISMATCH, -1, signed score added to diag on a mismatch
- GAP, -2, signed score added to up/left, and the border step
- BitAddr, $clog2(N+1), derived; index ports are [BitAddr:0]

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a fill; sampled only in IDLE
- match  in  1  symbol compare for the current cell (i+1, j+1); sampled in CALC
- signal  in  1  from the manager; any toggle means the 3 neighbour reads are complete
- diag, up, left  in  9 each  neighbour scores, 9-bit two's complement
- en_init  out  1  border-init enable
- we  out  1  RAM write enable
- addr_init  out  BitAddr+1  border index k
- data_init  out  9  border score k*GAP
- en_read  out  1  neighbour-read enable
- en_ins  out  1  cell-insert enable
- i, j  out  BitAddr+1 each  cell index; the manager addresses (i+1, j+1)
- max  out  9  computed cell score
- change_index  out  1  one-cycle pulse after each insert
- busy  out  1  high from the start accept until the DONE state
- done  out  1  one-cycle pulse when the fill completes

## Operation
- States: IDLE, INIT, READ, CALC, WRITE, NEXT, DONE.
- IDLE
  - start=1 moves to INIT and clears k, i and j.
  - start in any other state is ignored.
- INIT
  - Drives en_init=1, we=1, addr_init=k, data_init=k*GAP, for k=0..N, one k per cycle.
  - After k=N, moves to READ.
- READ
  - Drives en_read=1.
  - A registered copy of signal is kept; when signal differs from it, moves to CALC.
  - No timeout: the FSM waits indefinitely.
- CALC
  - Computes max = max3(diag+(match?MATCH:MISMATCH), up+GAP, left+GAP).
  - The sums are computed at 10 bits, then saturated to [-256, 255].
  - max is registered on exit from CALC.
- WRITE
  - Drives en_ins=1 and we=1 for one cycle, with i, j and max stable.
- NEXT
  - Pulses change_index.
  - If j<N-1: j++. Else j=0 and i++.
  - If the cell just written was (N-1, N-1), moves to DONE. Otherwise moves to READ.
- DONE
  - Pulses done=1 and drops busy.
  - Moves to IDLE next cycle.
- Edge-detect register: reloaded with signal on every cycle outside READ, so a toggle arriving outside READ is not counted.

## Timing
- Reset values: every output is 0, state is IDLE, the edge-detect register is loaded with the current signal.
- rst mid-fill: takes effect on the next edge. No done pulse is produced, and RAM contents are not restored.
- start to first en_init: 1 cycle. INIT lasts N+1 cycles.
- Per cell: t_read + 3 cycles, where t_read is the number of cycles from READ entry up to and including the cycle in which the toggle is seen.
- en_init/en_read/en_ins: mutually exclusive in every cycle.
- Simultaneous start and rst: rst wins.

## Structure
- Package nw_pkg holds:
  - SCORE_W=9
  - the state enum
  - the default MATCH/MISMATCH/GAP constants
  - the saturate function
- Sub-module nw_max3: combinational, with 9-bit signed inputs diag/up/left, input match, and output max. It contains the add-and-saturate logic and is instantiated once in CALC.

## Test plan
- N=2, start pulse -> INIT writes (0,0), (1,-2), (2,-4) on consecutive cycles with we=1; busy rises 1 cycle after start.
- Cell (0,0): diag=0, up=-2, left=-2, match=1; manager toggles signal 3 cycles after en_read -> max=1, one en_ins cycle, then change_index, then i=0, j=1.
- Saturation: diag=255, match=1 -> max=255. Then diag=-256, up=left=-256, match=0 -> max=-256.
- Full N=2 fill with a 3-cycle read response -> exactly 4 en_ins pulses at (0,0), (0,1), (1,0), (1,1), then a single done pulse. Total from start accept to done = 3 INIT + 4 cells x (3 read + 3) = 27 cycles; check the exact count at the bench against the t_read definition.
- start asserted during READ, and a signal toggle during WRITE -> both ignored; the sequence and cell count are unchanged.
- rst asserted in READ of cell (1,0) -> next cycle all outputs are 0 and state is IDLE, no done. A fresh start then restarts INIT at k=0.
